// File: rtl/reset_sequencer.sv
// reset_sequencer: combines the pushbutton, PLL lock flags and a software
// request into a single fault condition. While a fault is present all resets
// are held. After the fault clears, the resets are held for a further stretch
// period and then released one domain at a time. CAUSE records which sources
// produced the most recent reset.
module reset_sequencer #(
    parameter int NUM_LOCK    = 2,
    parameter int NUM_OUT     = 3,
    parameter int STRETCH     = 255,
    parameter int GAP         = 16,
    parameter int DEBOUNCE    = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                BTN,
    input  logic [NUM_LOCK-1:0] LOCKED,
    input  logic                SW_RESET,
    output logic [NUM_OUT-1:0]  RESETn,
    output logic                BUSY,
    output logic [3:0]          CAUSE
);

    // One counter width covers stretch, gap and debounce terminal counts.
    localparam int MAX_SG  = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int MAX_CNT = (MAX_SG > DEBOUNCE) ? MAX_SG : DEBOUNCE;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Start-up qualifier. Bit 0 rises one edge after RESET is released and
    // enables the synchronisers; the top bit rises once the synchroniser
    // chains hold genuinely sampled data. Until then the all-zero chain
    // contents are not treated as a lock loss or button press.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES:0] warm_reg;
    logic                 sync_en;
    logic                 warm_done;

    // Shift ones into the start-up qualifier after reset release.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            warm_reg <= '0;
        end else begin
            warm_reg <= {warm_reg[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sync_en   = warm_reg[0];
    assign warm_done = warm_reg[SYNC_STAGES];

    // ------------------------------------------------------------------
    // Synchronisers for the asynchronous inputs.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] btn_sh_reg;
    logic                   btn_sync;
    logic [NUM_LOCK-1:0]    lock_sync;

    // Button synchroniser chain.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            btn_sh_reg <= '0;
        end else if (sync_en) begin
            btn_sh_reg <= {btn_sh_reg[SYNC_STAGES-2:0], BTN};
        end
    end

    assign btn_sync = btn_sh_reg[SYNC_STAGES-1];

    generate
        for (genvar gi = 0; gi < NUM_LOCK; gi++) begin : g_lock_sync
            logic [SYNC_STAGES-1:0] lock_sh_reg;

            // Synchroniser chain for one LOCKED bit.
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    lock_sh_reg <= '0;
                end else if (sync_en) begin
                    lock_sh_reg <= {lock_sh_reg[SYNC_STAGES-2:0], LOCKED[gi]};
                end
            end

            assign lock_sync[gi] = lock_sh_reg[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Button debounce: the debounced level follows the synchronised level
    // only after DEBOUNCE consecutive cycles of disagreement.
    // ------------------------------------------------------------------
    logic             btn_db_reg;
    logic [CNT_W-1:0] db_cnt_reg;

    // Count consecutive disagreeing cycles and flip the debounced level.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            btn_db_reg <= 1'b0;
            db_cnt_reg <= '0;
        end else if (btn_sync == btn_db_reg) begin
            db_cnt_reg <= '0;
        end else if (db_cnt_reg == DEB_LAST) begin
            btn_db_reg <= btn_sync;
            db_cnt_reg <= '0;
        end else begin
            db_cnt_reg <= db_cnt_reg + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Fault sources, laid out in CAUSE bit positions (bit 0 is never a
    // runtime source; it is only set by RESET).
    // ------------------------------------------------------------------
    logic [3:0] fault_src;
    logic       fault;

    assign fault_src = {SW_RESET,
                        warm_done & ~&lock_sync,
                        warm_done & btn_db_reg,
                        1'b0};
    assign fault     = (|fault_src) | ~warm_done;

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs. seq_cnt_reg serves as the
    // stretch counter in STRETCH and as the gap counter in RELEASE.
    // ------------------------------------------------------------------
    state_t             state_reg;
    logic [NUM_OUT-1:0] resetn_reg;
    logic               busy_reg;
    logic [3:0]         cause_reg;
    logic [CNT_W-1:0]   seq_cnt_reg;
    logic [IDX_W-1:0]   idx_reg;

    // Hold, stretch, stage-release and run sequencing of the reset outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg   <= ST_ASSERT;
            resetn_reg  <= '0;
            busy_reg    <= 1'b1;
            cause_reg   <= 4'b0001;
            seq_cnt_reg <= '0;
            idx_reg     <= '0;
        end else if ((state_reg != ST_ASSERT) && fault) begin
            // Any fault outside ASSERT drops every domain at once and
            // replaces the recorded cause with the sources active now.
            state_reg   <= ST_ASSERT;
            resetn_reg  <= '0;
            busy_reg    <= 1'b1;
            cause_reg   <= fault_src;
            seq_cnt_reg <= '0;
            idx_reg     <= '0;
        end else begin
            case (state_reg)
                ST_ASSERT: begin
                    resetn_reg  <= '0;
                    busy_reg    <= 1'b1;
                    seq_cnt_reg <= '0;
                    idx_reg     <= '0;
                    cause_reg   <= cause_reg | fault_src;
                    if (!fault) begin
                        state_reg <= ST_STRETCH;
                    end
                end

                ST_STRETCH: begin
                    if (seq_cnt_reg == STRETCH_LAST) begin
                        seq_cnt_reg   <= '0;
                        resetn_reg[0] <= 1'b1;
                        idx_reg       <= IDX_W'(1);
                        if (NUM_OUT == 1) begin
                            state_reg <= ST_RUN;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg <= ST_RELEASE;
                        end
                    end else begin
                        seq_cnt_reg <= seq_cnt_reg + CNT_W'(1);
                    end
                end

                ST_RELEASE: begin
                    if (seq_cnt_reg == GAP_LAST) begin
                        seq_cnt_reg         <= '0;
                        resetn_reg[idx_reg] <= 1'b1;
                        if (idx_reg == IDX_LAST) begin
                            state_reg <= ST_RUN;
                            busy_reg  <= 1'b0;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end else begin
                        seq_cnt_reg <= seq_cnt_reg + CNT_W'(1);
                    end
                end

                ST_RUN: begin
                    resetn_reg <= '1;
                    busy_reg   <= 1'b0;
                end

                default: begin
                    state_reg  <= ST_ASSERT;
                    resetn_reg <= '0;
                    busy_reg   <= 1'b1;
                end
            endcase
        end
    end

    assign RESETn = resetn_reg;
    assign BUSY   = busy_reg;
    assign CAUSE  = cause_reg;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised power-on and reset sequencer that replaces the single fixed countdown at the FPGA top level. It combines the pushbutton, any number of PLL lock inputs and a software reset request into one fault condition. The button is synchronised and debounced; lock inputs are synchronised. After every fault the block holds all resets for a programmable stretch period, then releases several active-low reset domains in a fixed staged order and records the cause of the last reset.

Parameters:
NUM_LOCK, 2, number of PLL/MMCM LOCKED inputs; all must be high for the system to run.
NUM_OUT, 3, number of staged active-low reset outputs. Bit 0 releases first.
STRETCH, 255, cycles of continuous fault-free condition required before the first release. Must be at least 1.
GAP, 16, cycles between consecutive output releases. Must be at least 1.
DEBOUNCE, 1000, consecutive stable cycles required before the debounced button changes level.
SYNC_STAGES, 2, synchroniser depth on BTN and each LOCKED bit. Must be at least 2.

Ports:
CLK  input  1  system clock.
RESET  input  1  asynchronous, active-high reset for the whole block.
BTN  input  1  raw pushbutton, active-high, asynchronous to CLK.
LOCKED  input  NUM_LOCK  PLL lock flags, asynchronous to CLK.
SW_RESET  input  1  single-cycle software reset request, synchronous to CLK.
RESETn  output  NUM_OUT  registered active-low resets, one per domain.
BUSY  output  1  high whenever the FSM is not in RUN.
CAUSE  output  4  last reset cause: bit 3 software, bit 2 lock loss, bit 1 button, bit 0 power-on/RESET.

Behaviour:
- Async RESET high: state=ASSERT, RESETn=0, BUSY=1, CAUSE=4'b0001. All synchronisers, btn_db, counters and idx are 0. Release is synchronous to CLK.
- Sync: lock_sync and btn_sync each pass through SYNC_STAGES flops.
- Debounce: btn_db takes the value of btn_sync after btn_sync has differed from btn_db for DEBOUNCE consecutive cycles. The debounce counter clears on any cycle where they match.
- fault = btn_db | ~&lock_sync | SW_RESET, evaluated combinationally from registered signals.
- ASSERT state:
  - RESETn is all 0.
  - On the edge where fault=0, go to STRETCH with cnt=0.
  - Every fault source active in ASSERT is ORed into CAUSE.
- STRETCH state:
  - If fault=1, go to ASSERT.
  - Otherwise cnt increments. When cnt==STRETCH-1, go to RELEASE, RESETn[0] goes to 1, idx=1 and gap counter=0.
- Release timing: let T be the edge on which the FSM leaves ASSERT. RESETn[i] rises at edge T+STRETCH+i*GAP.
- RELEASE state:
  - If fault=1, go to ASSERT.
  - Otherwise the gap counter counts to GAP-1. It then sets RESETn[idx] and increments idx.
  - After the edge that sets RESETn[NUM_OUT-1], go to RUN.
  - If NUM_OUT==1, go directly from STRETCH to RUN.
- RUN state: RESETn is all 1. If fault=1, go to ASSERT.
- Entry to ASSERT from any other state:
  - On the same edge, RESETn becomes all 0 (one-cycle registered latency from fault), counters clear and idx=0.
  - CAUSE is loaded with exactly the fault bits active that cycle. Simultaneous sources set multiple bits.
- CAUSE holds its value in STRETCH, RELEASE and RUN.
- A SW_RESET pulse while already in ASSERT only ORs bit 3 into CAUSE.
- A glitch on LOCKED lasting one cycle after synchronisation is a fault. There is no lock filtering.
- Releases are strictly ordered. Outputs never re-assert individually; every assertion is all-at-once.
- Counters are sized $clog2(max(STRETCH,GAP,DEBOUNCE)+1). Nothing wraps: each counter stops at its terminal value.

Test Plan:
- Configuration for all scenarios: NUM_OUT=3, STRETCH=4, GAP=2, DEBOUNCE=3, SYNC_STAGES=2.
- Power-on: RESET high, then low before edge 0, with LOCKED=2'b11 constant and BTN=0 -> T=edge 3, RESETn[0]/[1]/[2] rise at edges 7/9/11, BUSY falls at edge 11, CAUSE=4'b0001.
- Lock loss in RUN: LOCKED[1]=0 for 1 cycle -> RESETn=000 two sync edges plus one later, CAUSE=4'b0100, then the full sequence repeats (STRETCH 4, GAP 2).
- Button bounce: BTN high for 2 cycles, then low -> no reset. BTN held high for 6 cycles -> btn_db rises 2+3 edges after BTN, RESETn=000 one edge later, CAUSE=4'b0010. Release starts after the debounced button falls.
- SW_RESET during RELEASE: pulse SW_RESET right after RESETn[0] rises -> RESETn=000 next edge, CAUSE=4'b1000, restart from STRETCH on the following edge.
- Simultaneous events: SW_RESET and lock loss on the same cycle in RUN -> CAUSE=4'b1100. Async RESET mid-RELEASE -> RESETn=000 with no clock edge, CAUSE=4'b0001.
